// File: rtl/uart_tx_scheduler.sv
// Byte FIFO between a CPU store port and a uart block: pops one byte per
// frame and strobes it to the uart, then waits FRAME_CYCLES before the next.
module uart_tx_scheduler #(
   parameter int FIFO_DEPTH   = 16,
   parameter int FRAME_CYCLES = 8680
) (
   input  logic                          sysclk,
   input  logic                          nrst,
   input  logic                          cpu_we,
   input  logic [7:0]                    cpu_data,
   output logic                          cpu_stall,
   output logic                          uart_wr_o,
   output logic [7:0]                    uart_dat_o,
   output logic [$clog2(FIFO_DEPTH):0]   level,
   output logic                          idle,
   output logic                          drop
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;
   localparam int CW = $clog2(FRAME_CYCLES);

   typedef enum logic {S_IDLE, S_WAIT} state_t;

   state_t          r_state;
   logic [CW-1:0]   r_cnt;
   logic [AW-1:0]   r_wr_ptr;
   logic [AW-1:0]   r_rd_ptr;
   logic [LW-1:0]   r_level;
   logic            r_wr;
   logic [7:0]      r_dat;
   logic            r_drop;
   logic [7:0]      r_mem [FIFO_DEPTH];

   logic            w_full;
   logic            w_push;
   logic            w_pop;

   // Full is taken from the registered level, so a same-cycle pop never frees a slot.
   assign w_full = (r_level == LW'(FIFO_DEPTH));
   assign w_push = cpu_we & ~w_full;
   assign w_pop  = (r_state == S_IDLE) & (r_level != '0);

   assign cpu_stall  = cpu_we & w_full;
   assign idle       = (r_level == '0) & (r_state == S_IDLE);
   assign uart_wr_o  = r_wr;
   assign uart_dat_o = r_dat;
   assign level      = r_level;
   assign drop       = r_drop;

   // Storage is deliberately left out of reset.
   always_ff @(posedge sysclk) begin
      if (nrst && w_push)
         r_mem[r_wr_ptr] <= cpu_data;
   end

   always_ff @(posedge sysclk) begin
      if (!nrst) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
         r_wr     <= 1'b0;
         r_dat    <= '0;
         r_drop   <= 1'b0;
      end else begin
         if (w_push)
            r_wr_ptr <= r_wr_ptr + 1'b1;
         else if (cpu_we)
            r_drop <= 1'b1;

         r_level <= r_level + LW'(w_push) - LW'(w_pop);

         case (r_state)
            S_IDLE: begin
               if (w_pop) begin
                  r_dat    <= r_mem[r_rd_ptr];
                  r_wr     <= 1'b1;
                  r_rd_ptr <= r_rd_ptr + 1'b1;
                  r_cnt    <= CW'(FRAME_CYCLES - 1);
                  r_state  <= S_WAIT;
               end else begin
                  r_wr <= 1'b0;
               end
            end
            S_WAIT: begin
               r_wr <= 1'b0;
               if (r_cnt == '0)
                  r_state <= S_IDLE;
               else
                  r_cnt <= r_cnt - 1'b1;
            end
            default: begin
               r_wr    <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: reference model plus byte scoreboard, a
// hand-computed vector table for the burst case, and directed corner sequences.
module tb_uart_tx_scheduler;

   localparam int DEPTH = 4;
   localparam int FRAME = 4;

   logic       sysclk = 1'b0;
   logic       nrst = 1'b0;
   logic       cpu_we = 1'b0;
   logic [7:0] cpu_data = '0;
   logic       cpu_stall;
   logic       uart_wr_o;
   logic [7:0] uart_dat_o;
   logic [2:0] level;
   logic       idle;
   logic       drop;

   uart_tx_scheduler #(.FIFO_DEPTH(DEPTH), .FRAME_CYCLES(FRAME)) dut (
      .sysclk     (sysclk),
      .nrst       (nrst),
      .cpu_we     (cpu_we),
      .cpu_data   (cpu_data),
      .cpu_stall  (cpu_stall),
      .uart_wr_o  (uart_wr_o),
      .uart_dat_o (uart_dat_o),
      .level      (level),
      .idle       (idle),
      .drop       (drop)
   );

   always #5 sysclk = ~sysclk;

   int n_total = 0;
   int n_bad   = 0;
   int cyc     = 0;
   int n_strobe = 0;
   int last_strobe = -100;
   int prev_strobe = -100;

   // Reference model state
   logic       m_wait = 1'b0;
   int         m_cnt = 0;
   int         m_level = 0;
   logic       m_wr = 1'b0;
   logic [7:0] m_dat = '0;
   logic       m_drop = 1'b0;
   logic [7:0] sb[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // One clock: drive inputs, advance the model, sample #1 after the edge.
   task automatic step(input logic we, input logic [7:0] d, input logic rst_n);
      logic acc;
      logic pop;
      logic [7:0] exp_b;
      cpu_we   = we;
      cpu_data = d;
      nrst     = rst_n;
      acc = rst_n && we && (m_level != DEPTH);
      pop = !m_wait && (m_level != 0);
      if (acc) sb.push_back(d);
      @(posedge sysclk);
      cyc++;
      if (!rst_n) begin
         m_wait = 1'b0; m_cnt = 0; m_level = 0;
         m_wr = 1'b0; m_dat = '0; m_drop = 1'b0;
         sb.delete();
      end else begin
         if (we && !acc) m_drop = 1'b1;
         m_wr = pop;
         if (!m_wait) begin
            if (pop) begin m_wait = 1'b1; m_cnt = FRAME - 1; end
         end else begin
            if (m_cnt == 0) m_wait = 1'b0;
            else m_cnt--;
         end
         m_level = m_level + int'(acc) - int'(pop);
      end
      #1;
      chk("wr", 32'(uart_wr_o), 32'(m_wr));
      if (uart_wr_o === 1'b1) begin
         n_strobe++;
         prev_strobe = last_strobe;
         last_strobe = cyc;
         if (sb.size() == 0) begin
            chk("strobe_without_data", 32'(1), 32'(0));
         end else begin
            exp_b = sb.pop_front();
            chk("data_order", 32'(uart_dat_o), 32'(exp_b));
            m_dat = exp_b;
         end
      end else begin
         chk("dat_hold", 32'(uart_dat_o), 32'(m_dat));
      end
      chk("level", 32'(level), 32'(m_level));
      chk("drop", 32'(drop), 32'(m_drop));
      chk("idle", 32'(idle), 32'((m_level == 0) && !m_wait));
      chk("stall", 32'(cpu_stall), 32'(we && (m_level == DEPTH)));
   endtask

   typedef struct {
      logic       we;
      logic [7:0] d;
      logic [2:0] lvl;
      logic       wr;
      logic [7:0] dat;
      logic       idl;
   } vec_t;

   vec_t tbl[13];

   initial begin
      int s0;
      // Burst of 01,02,03 from an idle block that last sent 8'h41.
      tbl[0]  = '{1'b1, 8'h01, 3'd1, 1'b0, 8'h41, 1'b0};
      tbl[1]  = '{1'b1, 8'h02, 3'd1, 1'b1, 8'h01, 1'b0};
      tbl[2]  = '{1'b1, 8'h03, 3'd2, 1'b0, 8'h01, 1'b0};
      tbl[3]  = '{1'b0, 8'h00, 3'd2, 1'b0, 8'h01, 1'b0};
      tbl[4]  = '{1'b0, 8'h00, 3'd2, 1'b0, 8'h01, 1'b0};
      tbl[5]  = '{1'b0, 8'h00, 3'd2, 1'b0, 8'h01, 1'b0};
      tbl[6]  = '{1'b0, 8'h00, 3'd1, 1'b1, 8'h02, 1'b0};
      tbl[7]  = '{1'b0, 8'h00, 3'd1, 1'b0, 8'h02, 1'b0};
      tbl[8]  = '{1'b0, 8'h00, 3'd1, 1'b0, 8'h02, 1'b0};
      tbl[9]  = '{1'b0, 8'h00, 3'd1, 1'b0, 8'h02, 1'b0};
      tbl[10] = '{1'b0, 8'h00, 3'd1, 1'b0, 8'h02, 1'b0};
      tbl[11] = '{1'b0, 8'h00, 3'd0, 1'b1, 8'h03, 1'b0};
      tbl[12] = '{1'b0, 8'h00, 3'd0, 1'b0, 8'h03, 1'b0};

      // Reset, edges 1..3
      for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0);
      chk("rst_level", 32'(level), 32'(0));
      chk("rst_wr", 32'(uart_wr_o), 32'(0));
      chk("rst_idle", 32'(idle), 32'(1));

      // Single byte pushed at edge 10
      for (int i = 0; i < 6; i++) step(1'b0, 8'h00, 1'b1);
      step(1'b1, 8'h41, 1'b1);
      chk("single_push_edge", 32'(cyc), 32'(10));
      step(1'b0, 8'h00, 1'b1);
      chk("single_wr11", 32'(uart_wr_o), 32'(1));
      chk("single_dat11", 32'(uart_dat_o), 32'(8'h41));
      step(1'b0, 8'h00, 1'b1);
      chk("single_wr12", 32'(uart_wr_o), 32'(0));
      chk("single_idle12", 32'(idle), 32'(0));
      for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1);
      chk("single_idle16", 32'(idle), 32'(1));
      for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1);

      // Burst ordering table
      s0 = n_strobe;
      for (int i = 0; i < 13; i++) begin
         step(tbl[i].we, tbl[i].d, 1'b1);
         chk($sformatf("tbl%0d_level", i), 32'(level), 32'(tbl[i].lvl));
         chk($sformatf("tbl%0d_wr", i), 32'(uart_wr_o), 32'(tbl[i].wr));
         chk($sformatf("tbl%0d_dat", i), 32'(uart_dat_o), 32'(tbl[i].dat));
         chk($sformatf("tbl%0d_idle", i), 32'(idle), 32'(tbl[i].idl));
      end
      chk("burst_strobes", 32'(n_strobe - s0), 32'(3));
      for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1);

      // Full and stall: 6 back-to-back writes, one is refused
      for (int i = 0; i < 6; i++) begin
         step(1'b1, 8'hA0 + 8'(i), 1'b1);
         if (i == 4) begin
            chk("full_level", 32'(level), 32'(4));
            chk("full_stall", 32'(cpu_stall), 32'(1));
            chk("full_nodrop_yet", 32'(drop), 32'(0));
         end
      end
      chk("full_drop", 32'(drop), 32'(1));
      for (int i = 0; i < 25; i++) step(1'b0, 8'h00, 1'b1);
      chk("full_drained", 32'(level), 32'(0));
      chk("drop_sticky", 32'(drop), 32'(1));

      // Pointer wrap: 10 bytes at line rate
      s0 = n_strobe;
      for (int b = 0; b < 10; b++) begin
         step(1'b1, 8'h10 + 8'(b), 1'b1);
         for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1);
      end
      for (int i = 0; i < 10; i++) step(1'b0, 8'h00, 1'b1);
      chk("wrap_count", 32'(n_strobe - s0), 32'(10));
      chk("wrap_last", 32'(uart_dat_o), 32'(8'h19));

      // Reset with 3 bytes buffered and the FSM waiting
      for (int i = 0; i < 6; i++) step(1'b1, 8'hC0 + 8'(i), 1'b1);
      step(1'b0, 8'h00, 1'b1);
      chk("pre_rst_level", 32'(level), 32'(3));
      chk("pre_rst_busy", 32'(idle), 32'(0));
      step(1'b0, 8'h00, 1'b0);
      chk("mid_rst_level", 32'(level), 32'(0));
      chk("mid_rst_wr", 32'(uart_wr_o), 32'(0));
      chk("mid_rst_drop", 32'(drop), 32'(0));
      s0 = n_strobe;
      for (int i = 0; i < 12; i++) step(1'b0, 8'h00, 1'b1);
      chk("post_rst_quiet", 32'(n_strobe - s0), 32'(0));

      // Push in the same cycle as the pop
      step(1'b1, 8'h5A, 1'b1);
      step(1'b1, 8'h5B, 1'b1);
      chk("simul_level", 32'(level), 32'(1));
      chk("simul_first", 32'(uart_dat_o), 32'(8'h5A));
      for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b1);
      chk("simul_gap", 32'(last_strobe - prev_strobe), 32'(5));
      chk("simul_second", 32'(uart_dat_o), 32'(8'h5B));
      chk("sb_empty", 32'(sb.size()), 32'(0));

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
